leaf_slice_array: RTL and testbench
===================================

LEAF_SLICE_ARRAY -- requirements
Module: leaf_slice_array

Interface
REQ-001 SHALL have parameter WIDTH, default 3, data bits per lane.
REQ-002 SHALL have parameter LANES, default 4, number of independent channels.
REQ-003 SHALL have parameter CNT_W, default 16, width of the transfer counter.
REQ-004 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, synchronous discard of all buffered data.
REQ-007 SHALL have port in_valid, input, LANES, per-lane producer valid.
REQ-008 SHALL have port in_ready, output, LANES, per-lane acceptance.
REQ-009 SHALL have port in_data, input, LANES*WIDTH, lane i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid, output, LANES, per-lane output valid.
REQ-011 SHALL have port out_ready, input, LANES, per-lane consumer ready.
REQ-012 SHALL have port out_data, output, LANES*WIDTH, with the same packing as in_data.
REQ-013 SHALL have port xfer_count, output, CNT_W, running count of output handshakes over all lanes.

Function
REQ-014 Lanes SHALL be fully independent; no lane's handshake affects another lane except through xfer_count.
REQ-015 In-fire SHALL be in_valid[i]&in_ready[i]; out-fire SHALL be out_valid[i]&out_ready[i].
REQ-016 Each lane SHALL hold a 2-entry skid buffer (main, skid) with states EMPTY, ONE, TWO.
REQ-017 From EMPTY: in-fire SHALL load main and go to ONE; otherwise stay EMPTY.
REQ-018 From ONE: in-fire with out-fire SHALL load main and stay ONE; in-fire alone SHALL load skid and go to TWO; out-fire alone SHALL go to EMPTY.
REQ-019 From TWO: out-fire SHALL move skid to main and go to ONE; otherwise stay TWO.
REQ-020 out_valid[i] SHALL be 1 iff the state is not EMPTY; out_data lane i SHALL be main, driven from registers only.
REQ-021 in_ready[i] SHALL equal (state != TWO) & !flush & !reset, with no dependence on out_ready.
REQ-022 Latency SHALL be one cycle: data accepted on edge N is presented on out_data after edge N.
REQ-023 Data order per lane SHALL be preserved; no datum SHALL be lost or duplicated except by flush or reset.
REQ-024 A lane with continuous in_valid and out_ready SHALL sustain one transfer per cycle.
REQ-025 On each edge, xfer_count SHALL add the popcount of out-fires, modulo 2^CNT_W (wraps silently).
REQ-026 flush SHALL force all lanes to EMPTY on the next edge; that cycle's inputs are refused (in_ready=0).
REQ-027 Out-fires in a flush cycle SHALL complete and be counted; xfer_count SHALL NOT be cleared by flush.
REQ-028 Lanes SHALL NOT interpret data content; all WIDTH bits pass unchanged.

Reset
REQ-029 While reset is high, on each edge all lanes SHALL go to EMPTY and xfer_count SHALL become 0.
REQ-030 During and after reset: out_valid=0 and out_data=0; in_ready=0 while reset is high and all 1 in the first cycle after release.
REQ-031 reset SHALL take precedence over flush and over any handshake in the same cycle, including mid-transfer.

Structure
REQ-032 A shared package SHALL hold the lane-state enum (EMPTY/ONE/TWO) and the default parameter constants.
REQ-033 One sub-module leaf_slice (single-lane skid buffer, WIDTH-parameterised) SHALL be instantiated LANES times.
REQ-034 The top level SHALL contain only lane slicing, the generate loop, the popcount and the counter.

Verification (WIDTH=3, LANES=4, CNT_W=16 unless noted)
REQ-035 After reset, lane0 sends 5 with out_ready=1 -> out_valid[0]=1 and out_data lane0=5 one cycle later; xfer_count=1 on the following edge.
REQ-036 With out_ready[1]=0, lane1 sends 1, 2, 3 -> only 1 and 2 are accepted and in_ready[1]=0 after the second accept; then out_ready[1]=1 -> outputs 1, 2 in order, then in_ready[1]=1.
REQ-037 All lanes stream 100 values with both sides held high -> zero bubbles, correct order on each lane, xfer_count=400.
REQ-038 Flush while lanes 0 and 2 are in TWO and lane 2 has out_ready=1 -> all out_valid=0 next cycle, the lane 2 datum is counted, the remaining data is dropped.
REQ-039 With CNT_W=4, run 17 single-lane transfers -> xfer_count=1 after the last one (wrap).
REQ-040 Assert reset mid-stream with TWO occupancy -> out_valid=0, xfer_count=0, in_ready=0 during reset, in_ready=4'b1111 one cycle after release.

Source files
------------

// File: rtl/leaf_slice_array_pkg.sv
// leaf_slice_array_pkg: shared lane-state enum and default parameters
// Provides lane_state_t (EMPTY/ONE/TWO) and the DEF_* parameter defaults.
package leaf_slice_array_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} lane_state_t;
  localparam int DEF_WIDTH = 3;
  localparam int DEF_LANES = 4;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/leaf_slice.sv
// leaf_slice: single-lane two-entry skid buffer
// Ports: clock, reset (sync, active-high), flush (drop buffered data),
//   in_valid/in_ready/in_data (producer side),
//   out_valid/out_ready/out_data (consumer side, out_data straight from main register).
module leaf_slice
  import leaf_slice_array_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  lane_state_t state, state_n;
  logic [WIDTH-1:0] main_q, skid_q, main_n, skid_n;
  logic in_fire, out_fire;
  assign in_ready  = (state != TWO) & !flush & !reset;
  assign out_valid = state != EMPTY;
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    case (state)
      EMPTY: if (in_fire) begin
        state_n = ONE;
        main_n  = in_data;
      end
      ONE: if (in_fire && out_fire) main_n = in_data;
      else if (in_fire) begin
        state_n = TWO;
        skid_n  = in_data;
      end else if (out_fire) state_n = EMPTY;
      TWO: if (out_fire) begin
        state_n = ONE;
        main_n  = skid_q;
      end
      default: state_n = EMPTY;
    endcase
    // flush only empties the lane; data registers hold their last contents
    if (flush) begin
      state_n = EMPTY;
      main_n  = main_q;
      skid_n  = skid_q;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end
endmodule

// File: rtl/leaf_slice_array.sv
// leaf_slice_array: LANES independent skid-buffer lanes with a shared transfer counter
// Ports: clock, reset (sync, active-high), flush, per-lane in_valid/in_ready/in_data,
//   per-lane out_valid/out_ready/out_data (lane i at [i*WIDTH +: WIDTH]),
//   xfer_count (wrapping count of output handshakes across all lanes).
module leaf_slice_array
  import leaf_slice_array_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [LANES-1:0]       in_valid,
  output logic [LANES-1:0]       in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       xfer_count
);
  logic [CNT_W-1:0] fires;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    leaf_slice #(.WIDTH(WIDTH)) u_slice (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid[i]),
      .in_ready (in_ready[i]),
      .in_data  (in_data[i*WIDTH +: WIDTH]),
      .out_valid(out_valid[i]),
      .out_ready(out_ready[i]),
      .out_data (out_data[i*WIDTH +: WIDTH])
    );
  end
  always_comb begin
    fires = '0;
    for (int j = 0; j < LANES; j++) fires = fires + CNT_W'(out_valid[j] & out_ready[j]);
  end
  always_ff @(posedge clock) begin
    if (reset) xfer_count <= '0;
    else xfer_count <= xfer_count + fires;
  end
endmodule

// File: tb/tb_leaf_slice_array.sv
// tb_leaf_slice_array: directed table plus streaming, flush, reset and wrap sequences
module tb_leaf_slice_array;
  logic clk = 0;
  logic rst, fl;
  logic [3:0] iv, ir, ov, ord;
  logic [11:0] id, od;
  logic [15:0] cnt;
  logic [3:0] w_iv, w_ir, w_ov, w_ord;
  logic [11:0] w_id, w_od;
  logic [3:0] w_cnt;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  leaf_slice_array #(.WIDTH(3), .LANES(4), .CNT_W(16)) dut (
    .clock(clk), .reset(rst), .flush(fl),
    .in_valid(iv), .in_ready(ir), .in_data(id),
    .out_valid(ov), .out_ready(ord), .out_data(od),
    .xfer_count(cnt)
  );

  leaf_slice_array #(.WIDTH(3), .LANES(4), .CNT_W(4)) dut_w (
    .clock(clk), .reset(rst), .flush(1'b0),
    .in_valid(w_iv), .in_ready(w_ir), .in_data(w_id),
    .out_valid(w_ov), .out_ready(w_ord), .out_data(w_od),
    .xfer_count(w_cnt)
  );

  typedef struct {
    logic rst, fl;
    logic [3:0] iv;
    logic [11:0] id;
    logic [3:0] ord;
    logic [3:0] e_ir, e_ov;
    logic [11:0] e_od;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pk(input int k);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*3 +: 3] = 3'((k + i) % 8);
    return r;
  endfunction

  initial begin
    w_iv = 0; w_ord = 0; w_id = 0;
    tbl[0]  = '{1, 0, 4'h0, 12'h000, 4'h0, 4'h0, 4'h0, 12'h000, 16'd0};
    tbl[1]  = '{0, 0, 4'h0, 12'h000, 4'h0, 4'hF, 4'h0, 12'h000, 16'd0};
    tbl[2]  = '{0, 0, 4'h1, 12'h005, 4'h1, 4'hF, 4'h1, 12'h005, 16'd0};
    tbl[3]  = '{0, 0, 4'h0, 12'h000, 4'h1, 4'hF, 4'h0, 12'h005, 16'd1};
    tbl[4]  = '{0, 0, 4'h2, 12'h008, 4'h0, 4'hF, 4'h2, 12'h00D, 16'd1};
    tbl[5]  = '{0, 0, 4'h2, 12'h010, 4'h0, 4'hF, 4'h2, 12'h00D, 16'd1};
    tbl[6]  = '{0, 0, 4'h2, 12'h018, 4'h0, 4'hD, 4'h2, 12'h00D, 16'd1};
    tbl[7]  = '{0, 0, 4'h0, 12'h000, 4'h2, 4'hD, 4'h2, 12'h015, 16'd2};
    tbl[8]  = '{0, 0, 4'h0, 12'h000, 4'h2, 4'hF, 4'h0, 12'h015, 16'd3};
    tbl[9]  = '{0, 0, 4'h0, 12'h000, 4'h0, 4'hF, 4'h0, 12'h015, 16'd3};
    tbl[10] = '{0, 0, 4'h5, 12'h183, 4'h0, 4'hF, 4'h5, 12'h193, 16'd3};
    tbl[11] = '{0, 0, 4'h5, 12'h1C4, 4'h0, 4'hF, 4'h5, 12'h193, 16'd3};
    tbl[12] = '{0, 1, 4'hF, 12'hFFF, 4'h4, 4'h0, 4'h0, 12'h193, 16'd4};
    tbl[13] = '{0, 0, 4'h0, 12'h000, 4'h0, 4'hF, 4'h0, 12'h193, 16'd4};
    tbl[14] = '{0, 0, 4'h1, 12'h001, 4'h0, 4'hF, 4'h1, 12'h191, 16'd4};
    tbl[15] = '{0, 0, 4'h1, 12'h002, 4'h0, 4'hF, 4'h1, 12'h191, 16'd4};
    tbl[16] = '{1, 1, 4'hF, 12'hFFF, 4'hF, 4'h0, 4'h0, 12'h000, 16'd0};
    tbl[17] = '{0, 0, 4'h0, 12'h000, 4'h0, 4'hF, 4'h0, 12'h000, 16'd0};
    for (int r = 0; r < 18; r++) begin
      rst = tbl[r].rst; fl = tbl[r].fl; iv = tbl[r].iv; id = tbl[r].id; ord = tbl[r].ord;
      #1;
      chk($sformatf("row%0d in_ready", r), 32'(ir), 32'(tbl[r].e_ir));
      @(posedge clk); #1;
      chk($sformatf("row%0d out_valid", r), 32'(ov), 32'(tbl[r].e_ov));
      chk($sformatf("row%0d out_data", r), 32'(od), 32'(tbl[r].e_od));
      chk($sformatf("row%0d xfer_count", r), 32'(cnt), 32'(tbl[r].e_cnt));
    end
    for (int k = 0; k < 100; k++) begin
      iv = 4'hF; ord = 4'hF; id = pk(k);
      #1;
      chk($sformatf("stream%0d in_ready", k), 32'(ir), 32'hF);
      @(posedge clk); #1;
      chk($sformatf("stream%0d out_valid", k), 32'(ov), 32'hF);
      chk($sformatf("stream%0d out_data", k), 32'(od), 32'(pk(k)));
    end
    iv = 0; ord = 4'hF; id = 0;
    @(posedge clk); #1;
    chk("stream drain out_valid", 32'(ov), 32'h0);
    chk("stream xfer_count", 32'(cnt), 32'd400);
    ord = 0;
    for (int k = 0; k < 17; k++) begin
      w_iv = 4'h1; w_ord = 4'h1; w_id = 12'(k % 8);
      @(posedge clk); #1;
      chk($sformatf("wrap%0d out_data", k), 32'(w_od[2:0]), 32'(k % 8));
      if (k == 16) chk("wrap count at 16", 32'(w_cnt), 32'd0);
    end
    w_iv = 0;
    @(posedge clk); #1;
    chk("wrap count final", 32'(w_cnt), 32'd1);
    chk("wrap drained", 32'(w_ov), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
